// File: rtl/scope_trigger_capture.sv
// Trigger detection and circular frame capture between the ADC sample stream
// and the dual-buffer waveform RAM.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for arm; no writes
// S_PRETRIG| filling the PRE history samples, crossings ignored
// S_ARMED  | testing every valid sample for a crossing or auto timeout
// S_POST   | filling the remaining DEPTH-PRE samples after the trigger
// S_DONE   | frame held for the display side; samples dropped until ack
module scope_trigger_capture #(
  parameter int SW      = 9,
  parameter int DW      = 16,
  parameter int DEPTH   = 640,
  parameter int AW      = 10,
  parameter int PRE     = 160,
  parameter int AUTO_TO = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          arm,
  input  logic          auto_mode,
  input  logic          rising,
  input  logic [SW-1:0] trig_level,
  input  logic [SW-1:0] sample,
  input  logic          sample_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          frame_done,
  output logic [AW-1:0] frame_start,
  output logic          triggered,
  input  logic          frame_ack,
  output logic          busy
);

  localparam int POST_N = DEPTH - PRE;
  localparam int CW     = AW + 1;
  localparam int TW     = $clog2(AUTO_TO + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
  localparam logic [CW-1:0] PRE_C     = CW'(PRE);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] POST_N_C  = CW'(POST_N);
  localparam logic [TW-1:0] TO_LAST   = TW'(AUTO_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRETRIG,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_ptr;
  logic [AW-1:0]   r_pre_cnt;
  logic [CW-1:0]   r_post_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic [SW-1:0]   r_prev;
  logic            r_prev_vld;
  logic [AW-1:0]   r_trig_addr;
  logic            r_trig_real;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic            r_frame_done;
  logic [AW-1:0]   r_frame_start;
  logic            r_triggered;

  logic            w_capturing;
  logic            w_accept;
  logic [AW-1:0]   w_ptr_next;
  logic            w_cross_rise;
  logic            w_cross_fall;
  logic            w_real;
  logic            w_force;
  logic [CW-1:0]   w_post_inc;

  // Oldest frame address: PRE samples before the trigger, wrapped without underflow.
  function automatic logic [AW-1:0] start_of(input logic [AW-1:0] addr);
    logic [CW-1:0] a;
    a = {1'b0, addr};
    if (a >= PRE_C) return AW'(a - PRE_C);
    else            return AW'(a + DEPTH_C - PRE_C);
  endfunction

  assign w_capturing  = (r_state == S_PRETRIG) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_accept     = sample_valid && w_capturing;
  assign w_ptr_next   = (r_ptr == LAST_ADDR) ? '0 : r_ptr + 1'b1;
  assign w_cross_rise = (r_prev < trig_level) && (sample >= trig_level);
  assign w_cross_fall = (r_prev > trig_level) && (sample <= trig_level);
  // Without a previous sample there is nothing to cross from.
  assign w_real       = r_prev_vld && (rising ? w_cross_rise : w_cross_fall);
  assign w_force      = auto_mode && (r_to_cnt == TO_LAST);
  assign w_post_inc   = r_post_cnt + 1'b1;

  // Capture FSM with write path and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_pre_cnt     <= '0;
      r_post_cnt    <= '0;
      r_to_cnt      <= '0;
      r_prev        <= '0;
      r_prev_vld    <= 1'b0;
      r_trig_addr   <= '0;
      r_trig_real   <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_frame_done  <= 1'b0;
      r_frame_start <= '0;
      r_triggered   <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr  <= r_ptr;
        r_wr_data  <= {{(DW-SW){1'b0}}, sample};
        r_ptr      <= w_ptr_next;
        r_prev     <= sample;
        r_prev_vld <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_pre_cnt <= '0;
            r_to_cnt  <= '0;
            r_state   <= (PRE == 0) ? S_ARMED : S_PRETRIG;
          end
        end

        S_PRETRIG: begin
          if (sample_valid) begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
            if (r_pre_cnt == PRE_LAST) r_state <= S_ARMED;
          end
        end

        S_ARMED: begin
          if (sample_valid) begin
            if (w_real || w_force) begin
              r_trig_addr <= r_ptr;
              r_trig_real <= w_real;
              r_post_cnt  <= CW'(1);
              if (POST_N == 1) begin
                r_state       <= S_DONE;
                r_frame_done  <= 1'b1;
                r_frame_start <= start_of(r_ptr);
                r_triggered   <= w_real;
              end else begin
                r_state <= S_POST;
              end
            end else if (r_to_cnt != TO_LAST) begin
              // Saturate so enabling auto_mode late still forces promptly.
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end

        S_POST: begin
          if (sample_valid) begin
            r_post_cnt <= w_post_inc;
            if (w_post_inc == POST_N_C) begin
              r_state       <= S_DONE;
              r_frame_done  <= 1'b1;
              r_frame_start <= start_of(r_trig_addr);
              r_triggered   <= r_trig_real;
            end
          end
        end

        S_DONE: begin
          // A simultaneous arm is dropped; the display must re-arm explicitly.
          if (frame_ack) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_done  = r_frame_done;
  assign frame_start = r_frame_start;
  assign triggered   = r_triggered;
  assign busy        = w_capturing;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Bench for scope_trigger_capture: queue-based capture model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_scope_trigger_capture;
  localparam int SW = 9, DW = 16, DEPTH = 16, AW = 4, PRE = 4, AUTO_TO = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm = 1'b0;
  logic          auto_mode = 1'b0;
  logic          rising = 1'b1;
  logic [SW-1:0] trig_level = '0;
  logic [SW-1:0] sample = '0;
  logic          sample_valid = 1'b0;
  logic          frame_ack = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_done;
  logic [AW-1:0] frame_start;
  logic          triggered;
  logic          busy;

  scope_trigger_capture #(
    .SW(SW), .DW(DW), .DEPTH(DEPTH), .AW(AW), .PRE(PRE), .AUTO_TO(AUTO_TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .auto_mode(auto_mode),
    .rising(rising), .trig_level(trig_level), .sample(sample),
    .sample_valid(sample_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .frame_start(frame_start),
    .triggered(triggered), .frame_ack(frame_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int frames_dut = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase 0: idle, 1: collecting a capture, 2: frame held
  int m_phase = 0;
  int m_ptr = 0;
  int m_start_ptr = 0;
  int m_trig_idx = -1;
  int m_prev = 0;
  bit m_prev_vld = 0;
  int q_cap[$];
  bit e_wr_en = 0, e_done = 0, e_trig = 0, e_busy = 0;
  int e_addr = 0, e_data = 0, e_start = 0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_phase = 0; m_ptr = 0; m_trig_idx = -1; m_prev = 0; m_prev_vld = 0;
      q_cap.delete();
      e_wr_en = 0; e_done = 0; e_trig = 0; e_busy = 0;
      e_addr = 0; e_data = 0; e_start = 0;
    end else begin
      e_wr_en = 0;
      case (m_phase)
        0: if (arm) begin
          m_phase = 1; q_cap.delete(); m_start_ptr = m_ptr; m_trig_idx = -1;
        end
        1: if (sample_valid) begin
          int cur, lvl, n;
          bit hit_real, hit_force;
          cur = int'(sample);
          lvl = int'(trig_level);
          e_wr_en = 1; e_addr = m_ptr; e_data = cur;
          m_ptr = (m_ptr + 1) % DEPTH;
          q_cap.push_back(cur);
          n = q_cap.size();
          if (m_trig_idx < 0 && n > PRE) begin
            hit_real  = m_prev_vld && (rising ? (m_prev < lvl && cur >= lvl)
                                              : (m_prev > lvl && cur <= lvl));
            hit_force = auto_mode && ((n - PRE) >= AUTO_TO);
            if (hit_real || hit_force) begin
              m_trig_idx = n - 1;
              e_trig = hit_real;
            end
          end
          if (m_trig_idx >= 0 && (n - m_trig_idx) == DEPTH - PRE) begin
            m_phase = 2;
            e_done = 1;
            e_start = (m_start_ptr + m_trig_idx - PRE) % DEPTH;
          end
          m_prev = cur; m_prev_vld = 1;
        end
        2: if (frame_ack) begin
          m_phase = 0; e_done = 0;
        end
        default: m_phase = 0;
      endcase
      e_busy = (m_phase == 1);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [DW-1:0] mirror [DEPTH];
  bit done_seen = 0;
  bit dut_done_q = 0;

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      check("wr_en", wr_en, e_wr_en);
      check("busy", busy, e_busy);
      check("frame_done", frame_done, e_done);
      if (wr_en) mirror[wr_addr] = wr_data;
      if (e_wr_en) begin
        check("wr_addr", wr_addr, e_addr);
        check("wr_data", wr_data, e_data);
      end
      if (e_done) begin
        check("frame_start", frame_start, e_start);
        check("triggered", triggered, e_trig);
      end
      if (e_done && !done_seen) begin
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++)
          if (int'(mirror[(e_start + i) % DEPTH]) != q_cap[q_cap.size() - DEPTH + i]) bad++;
        check("frame_content_bad_words", bad, 0);
      end
      done_seen = e_done;
      if (frame_done && !dut_done_q) frames_dut++;
      dut_done_q = frame_done;
    end else begin
      done_seen = 0;
      dut_done_q = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; arm = 1'b0; frame_ack = 1'b0; sample_valid = 1'b0; auto_mode = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic feed(input int v);
    sample = SW'(v); sample_valid = 1'b1; tick();
  endtask

  task automatic ack();
    sample_valid = 1'b0; frame_ack = 1'b1; tick(); frame_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_triggered"}, triggered, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    // 1: idle after reset, valid samples never written
    do_reset();
    check_all_zero("reset");
    sample_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample = SW'($urandom_range(0, 511));
      tick();
    end
    check_all_zero("idle20");

    // 2: rising ramp, trigger on 10
    do_reset();
    rising = 1'b1; trig_level = 9'd10;
    pulse_arm();
    feed(0);
    check("t2_first_addr", wr_addr, 0);
    check("t2_first_en", wr_en, 1);
    for (int v = 1; v <= 21; v++) begin
      feed(v);
      if (v == 10) check("t2_trig_addr", wr_addr, 10);
      if (v == 20) check("t2_not_done_early", frame_done, 0);
    end
    check("t2_last_addr", wr_addr, 5);
    check("t2_done", frame_done, 1);
    check("t2_start", frame_start, 6);
    check("t2_triggered", triggered, 1);
    check("t2_model_start", e_start, 6);
    sample_valid = 1'b0;
    ack();
    check("t2_ack_done", frame_done, 0);
    check("t2_ack_busy", busy, 0);

    // 3: falling, level 5
    do_reset();
    rising = 1'b0; trig_level = 9'd5;
    pulse_arm();
    begin
      int seq[8] = '{9, 9, 9, 9, 9, 5, 5, 3};
      for (int i = 0; i < 8; i++) begin
        feed(seq[i]);
        if (i == 5) check("t3_trig_addr", wr_addr, 5);
      end
    end
    for (int i = 0; i < 9; i++) feed(9);
    check("t3_done", frame_done, 1);
    check("t3_start", frame_start, 1);
    check("t3_triggered", triggered, 1);
    ack();

    // 4: auto trigger on the 8th armed sample
    do_reset();
    rising = 1'b1; trig_level = 9'd10; auto_mode = 1'b1;
    pulse_arm();
    for (int i = 0; i < 22; i++) feed(7);
    check("t4_not_done_22", frame_done, 0);
    feed(7);
    check("t4_done_23", frame_done, 1);
    check("t4_start", frame_start, 7);
    check("t4_triggered", triggered, 0);
    check("t4_model_trig", e_trig, 0);
    auto_mode = 1'b0;
    // arm and ack together in DONE: back to idle only
    sample_valid = 1'b0; arm = 1'b1; frame_ack = 1'b1; tick(); arm = 1'b0; frame_ack = 1'b0;
    tick();
    check("t4_arm_ack_busy", busy, 0);
    check("t4_arm_ack_done", frame_done, 0);

    // 5: gapped valid, arm ignored in POST, pointer continues
    do_reset();
    rising = 1'b1; trig_level = 9'd10;
    pulse_arm();
    for (int v = 0; v <= 21; v++) begin
      feed(v);
      check("t5_wr_en_valid", wr_en, 1);
      check("t5_addr", wr_addr, v % DEPTH);
      sample_valid = 1'b0;
      if (v == 14) arm = 1'b1;
      tick();
      arm = 1'b0;
      check("t5_wr_en_gap", wr_en, 0);
    end
    check("t5_done", frame_done, 1);
    check("t5_start", frame_start, 6);
    ack();
    pulse_arm();
    feed(100);
    check("t5_ptr_continues", wr_addr, 6);
    sample_valid = 1'b0;

    // 6: asynchronous reset mid-POST
    do_reset();
    rising = 1'b1; trig_level = 9'd10;
    pulse_arm();
    for (int v = 0; v <= 12; v++) feed(v);
    sample = 9'd13; sample_valid = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_wr_en", wr_en, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", frame_done, 0);
    sample_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("t6_idle_busy", busy, 0);
    pulse_arm();
    feed(0);
    check("t6_restart_addr", wr_addr, 0);
    check("t6_restart_busy", busy, 1);
    for (int v = 1; v <= 21; v++) feed(v);
    check("t6_done", frame_done, 1);
    check("t6_start", frame_start, 6);
    ack();

    // random traffic against the model
    do_reset();
    frames_dut = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        trig_level = SW'($urandom_range(0, 511));
        rising = 1'($urandom_range(0, 1));
        auto_mode = 1'($urandom_range(0, 1));
      end
      arm = ($urandom_range(0, 9) == 0);
      frame_ack = ($urandom_range(0, 5) == 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) begin
        sample = SW'($urandom_range(0, 511));
      end else begin
        int t, d;
        d = int'($urandom_range(0, 20));
        t = int'(trig_level) + d - 10;
        if (t < 0) t = 0;
        if (t > 511) t = 511;
        sample = SW'(t);
      end
      tick();
    end
    arm = 1'b0; frame_ack = 1'b0; sample_valid = 1'b0;
    tick();
    check("rand_frames_seen", (frames_dut >= 5) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
